// File: rtl/fwd_scoreboard_if.sv
// Forwarding scoreboard types and the decode-side bundle.
// Decode drives the stage-advance controls and reads back source selects.
package fwd_pkg;

  typedef struct packed {
    logic ex;
    logic mem0;
    logic mem1;
  } fwd_type_t;

endpackage

interface fwd_if;
  import fwd_pkg::*;

  logic            de_pending;
  logic            de_adv;
  logic [4:0]      de_rs1;
  logic [4:0]      de_rs2;
  logic [4:0]      de_wb_reg;
  logic            de_load;
  logic            ex_adv;
  logic            mem0_adv;
  logic            mem1_adv;
  logic            ex_flush;
  logic            cnt_clr;
  fwd_type_t       fwd_rs1;
  fwd_type_t       fwd_rs2;
  logic            fwd_stall;
  logic [15:0]     stall_cnt;

  modport master (
    output de_pending,
    output de_adv,
    output de_rs1,
    output de_rs2,
    output de_wb_reg,
    output de_load,
    output ex_adv,
    output mem0_adv,
    output mem1_adv,
    output ex_flush,
    output cnt_clr,
    input  fwd_rs1,
    input  fwd_rs2,
    input  fwd_stall,
    input  stall_cnt
  );

  modport slave (
    input  de_pending,
    input  de_adv,
    input  de_rs1,
    input  de_rs2,
    input  de_wb_reg,
    input  de_load,
    input  ex_adv,
    input  mem0_adv,
    input  mem1_adv,
    input  ex_flush,
    input  cnt_clr,
    output fwd_rs1,
    output fwd_rs2,
    output fwd_stall,
    output stall_cnt
  );

endinterface

// File: rtl/fwd_scoreboard.sv
// Tracks destinations in EX/M0/M1 and picks the youngest bypass source.
// Loads stall decode until their data reaches memory1.
module fwd_scoreboard
  import fwd_pkg::*;
(
  input  logic  clk_core,
  input  logic  reset_n,
  fwd_if.slave  sb
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  slot_t       ex_q;
  slot_t       ex_d;
  slot_t       m0_q;
  slot_t       m0_d;
  slot_t       m1_q;
  slot_t       m1_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  fwd_type_t   sel1;
  fwd_type_t   sel2;
  logic        ld1;
  logic        ld2;
  logic        stall;

  function automatic logic hit(
    input slot_t      s,
    input logic [4:0] rs
  );
    return s.v && (s.rd == rs) && (rs != 5'd0);
  endfunction

  function automatic fwd_type_t pick(
    input slot_t      e,
    input slot_t      m0,
    input slot_t      m1,
    input logic [4:0] rs
  );
    fwd_type_t f;
    f = '0;
    if (hit(e, rs)) begin
      f.ex = 1'b1;
    end else if (hit(m0, rs)) begin
      f.mem0 = 1'b1;
    end else if (hit(m1, rs)) begin
      f.mem1 = 1'b1;
    end
    return f;
  endfunction

  // Only the selected (youngest) producer decides the stall.
  function automatic logic sel_ld(
    input fwd_type_t f,
    input slot_t     e,
    input slot_t     m0,
    input slot_t     m1
  );
    return (f.ex & e.ld)
         | (f.mem0 & m0.ld)
         | (f.mem1 & m1.ld);
  endfunction

  always_comb begin
    sel1  = pick(ex_q, m0_q, m1_q, sb.de_rs1);
    sel2  = pick(ex_q, m0_q, m1_q, sb.de_rs2);
    ld1   = sel_ld(sel1, ex_q, m0_q, m1_q);
    ld2   = sel_ld(sel2, ex_q, m0_q, m1_q);
    stall = sb.de_pending & (ld1 | ld2);
  end

  always_comb begin
    ex_d = ex_q;
    if (sb.ex_flush) begin
      ex_d.v = 1'b0;
    end else if (sb.de_adv) begin
      ex_d.v  = 1'b1;
      ex_d.rd = sb.de_wb_reg;
      ex_d.ld = sb.de_load;
    end else if (sb.ex_adv) begin
      ex_d.v = 1'b0;
    end
  end

  always_comb begin
    m0_d = m0_q;
    if (sb.ex_adv && !sb.ex_flush) begin
      m0_d = ex_q;
    end else if (sb.mem0_adv) begin
      m0_d.v = 1'b0;
    end
  end

  // Data is forwardable once in memory1, so ld is dropped here.
  always_comb begin
    m1_d = m1_q;
    if (sb.mem0_adv) begin
      m1_d.v  = m0_q.v;
      m1_d.rd = m0_q.rd;
      m1_d.ld = 1'b0;
    end else if (sb.mem1_adv) begin
      m1_d.v = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (sb.cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      ex_q        <= SLOT_NONE;
      m0_q        <= SLOT_NONE;
      m1_q        <= SLOT_NONE;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      m0_q        <= m0_d;
      m1_q        <= m1_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.fwd_rs1   = sel1;
  assign sb.fwd_rs2   = sel2;
  assign sb.fwd_stall = stall;
  assign sb.stall_cnt = stall_cnt_q;

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk_core  in  1  core clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- de_pending  in  1  decode holds an instruction, pre-stall.
- de_adv  in  1  decode instruction issues to execute this cycle (decode de_valid).
- de_rs1, de_rs2  in  5 each  decode source registers.
- de_wb_reg  in  5  destination of issuing instruction; 0 = no write.
- de_load  in  1  issuing instruction is a LOAD; result available only from memory1.
- ex_adv, mem0_adv, mem1_adv  in  1 each  instruction leaves execute / memory0 / memory1 this cycle.
- ex_flush  in  1  squash the instruction held in execute.
- cnt_clr  in  1  clear stall counter.
- fwd_rs1, fwd_rs2  out  fwd_type_t each  one-hot source select {ex, mem0, mem1}; all 0 = register file.
- fwd_stall  out  1  decode must hold this cycle.
- stall_cnt  out  16  saturating count of fwd_stall cycles.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-003 SHALL hold three slots, EX, M0, M1, each {v, rd[4:0], ld}, mirroring the destination of the instruction in that stage.
REQ-004 EX next: ex_flush -> v=0; else de_adv -> {1, de_wb_reg, de_load}; else ex_adv -> v=0; else hold.
REQ-005 M0 next: ex_adv & ~ex_flush -> EX contents; else mem0_adv -> v=0; else hold.
REQ-006 M1 next: mem0_adv -> M0 contents with ld forced 0 (data now forwardable); else mem1_adv -> v=0; else hold.
REQ-007 M1 slot ld SHALL be 0 always; a load in M1 forwards normally via mem1.
REQ-008 Slot match for rsN: slot.v & slot.rd==rsN & rsN!=0; rd==0 SHALL never match.
REQ-009 fwd_rsN SHALL select the youngest matching slot: EX over M0 over M1; at most one bit set.
REQ-010 fwd_rsN SHALL be combinational from current slot state and de_rsN; independent of de_pending.
REQ-011 fwd_stall = de_pending & (for rs1 or rs2: the selected slot has ld=1); an older non-load match SHALL NOT mask a younger load match.
REQ-012 fwd_stall SHALL be combinational, zero added latency; de_adv is never asserted while fwd_stall=1 (decode contract); if it is, REQ-004 still applies.
REQ-013 Simultaneous de_adv & ex_adv: EX loads new, M0 loads old EX, same edge.
REQ-014 Simultaneous ex_flush & ex_adv: EX content SHALL NOT reach M0.
REQ-015 Stalled stages (adv=0, no incoming) SHALL hold slot contents indefinitely.
REQ-016 stall_cnt SHALL increment each cycle fwd_stall=1, saturate at 16'hFFFF, and clear on cnt_clr; cnt_clr wins over increment.

Reset
REQ-017 reset_n=0 SHALL asynchronously clear all slot v, rd, ld and stall_cnt; outputs fwd_rs1/fwd_rs2=0, fwd_stall=0 while in reset.
REQ-018 Reset mid-operation SHALL discard all tracked writes; first post-reset cycle sources register file.

Verification
REQ-019 Issue ADD rd=5 (de_adv); next cycle de_rs1=5, de_pending=1 -> fwd_rs1.ex=1, fwd_stall=0.
REQ-020 Issue LOAD rd=7; next cycle de_rs2=7 -> fwd_rs2.ex=1, fwd_stall=1; after ex_adv, mem0_adv -> fwd_rs2.mem1=1, fwd_stall=0; stall_cnt=2.
REQ-021 ADD rd=3 in M1, LOAD rd=3 in EX, de_rs1=3 -> fwd_rs1.ex=1, fwd_stall=1.
REQ-022 Issue rd=0 then de_rs1=0, de_rs2=0 -> fwd_rs1=fwd_rs2=0, fwd_stall=0.
REQ-023 rd=9 in EX, ex_flush & ex_adv same cycle -> next cycle M0.v=0, de_rs1=9 gives fwd_rs1=0.
REQ-024 Force fwd_stall 70000 cycles -> stall_cnt=16'hFFFF; cnt_clr pulse -> 0; assert reset_n=0 mid-run -> all outputs 0 immediately.
